// File: rtl/sd_otf_if.sv
// Handshake bundle between the online digit producer, the on-the-fly
// converter and the conventional result consumer.
//   Parameters: NO_OF_DIGITS (digits per operand), RADIX_BITS (digit width)
//   start      - begin / restart a conversion
//   din_valid  - signed digit on din is valid
//   din        - radix-4 signed digit, two's complement
//   din_ready  - converter accepts a digit this cycle
//   dout_valid - converted result available, held until accepted
//   dout       - two's-complement result, 2*NO_OF_DIGITS+1 bits
//   dout_ready - consumer takes dout
//   err        - sticky illegal-digit flag
// master: producer/consumer side; slave: converter side.
interface sd_otf_if #(
  parameter int NO_OF_DIGITS = 8,
  parameter int RADIX_BITS   = 3
);
  localparam int OUT_W = 2*NO_OF_DIGITS+1;

  logic                  start;
  logic                  din_valid;
  logic [RADIX_BITS-1:0] din;
  logic                  din_ready;
  logic                  dout_valid;
  logic [OUT_W-1:0]      dout;
  logic                  dout_ready;
  logic                  err;

  modport master (
    output start, din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout, err
  );

  modport slave (
    input  start, din_valid, din, dout_ready,
    output din_ready, dout_valid, dout, err
  );
endinterface

// File: rtl/sd_otf_converter.sv
// Serial radix-4 signed-digit to two's-complement converter using on-the-fly
// conversion. Digits arrive most-significant first; two candidate registers
// q and qm (always qm = q-1) let every digit be absorbed by a shift-and-append
// with a select between q and qm, so no carry ripples through the result.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - sd_otf_if.slave (start, din handshake, dout handshake, err)
// Optional feature macro: SD_CONV_CHECK_EN
//   defined   - accepting the digit pattern 100 (-4) sets the sticky err flag
//   undefined - err is tied to 0
// In both builds -4 is applied arithmetically as the value -4.
module sd_otf_converter #(
  parameter int NO_OF_DIGITS = 8,
  parameter int RADIX_BITS   = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  sd_otf_if.slave bus
);
  localparam int OUT_W = 2*NO_OF_DIGITS+1;
  localparam int CNT_W = $clog2(NO_OF_DIGITS+1);
  localparam logic [RADIX_BITS-1:0] DIG_MIN = {1'b1, {(RADIX_BITS-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NO_OF_DIGITS-1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] q, qm, q_nxt, qm_nxt, qm_dec;
  logic [CNT_W-1:0] cnt;
  logic             accept, last_digit;
  logic             is_neg, is_pos, is_min;
  logic [1:0]       lo_q, lo_qm;

  // A digit presented together with start is ignored.
  assign accept     = (state == CONV) && bus.din_valid && !bus.start;
  assign last_digit = (cnt == LAST_CNT);

  assign is_neg = bus.din[RADIX_BITS-1];
  assign is_pos = !bus.din[RADIX_BITS-1] && (bus.din != '0);
  assign is_min = (bus.din == DIG_MIN);

  // Appended bits: d mod 4 for q, (d-1) mod 4 for qm.
  assign lo_q   = bus.din[1:0];
  assign lo_qm  = bus.din[1:0] - 2'd1;
  assign qm_dec = qm - 1'b1;

  // q/qm selection. The -4 digit lies outside the radix-4 digit set, so
  // qm_new = 4*qm-1 cannot come from q or qm; it needs qm-1 shifted with 11.
  always_comb begin
    q_nxt  = is_neg ? {qm[OUT_W-3:0], lo_q} : {q[OUT_W-3:0], lo_q};
    qm_nxt = {qm[OUT_W-3:0], lo_qm};
    if (is_pos) begin
      qm_nxt = {q[OUT_W-3:0], lo_qm};
    end else if (is_min) begin
      qm_nxt = {qm_dec[OUT_W-3:0], 2'b11};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and digit-side ready; start restarts from any state.
  always_comb begin
    state_nxt     = state;
    bus.din_ready = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = CONV;
      end
      CONV: begin
        bus.din_ready = 1'b1;
        if (bus.start) state_nxt = CONV;
        else if (accept && last_digit) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) state_nxt = CONV;
        else if (bus.dout_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Candidate registers, digit counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q              <= '0;
      qm             <= '1;
      cnt            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else if (bus.start) begin
      q              <= '0;
      qm             <= '1;
      cnt            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else if (accept) begin
      q   <= q_nxt;
      qm  <= qm_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last_digit) begin
        bus.dout       <= q_nxt;
        bus.dout_valid <= 1'b1;
      end
    end else if ((state == DONE) && bus.dout_ready) begin
      bus.dout_valid <= 1'b0;
    end
  end

`ifdef SD_CONV_CHECK_EN
  // Sticky flag for an accepted -4 digit; cleared only by start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err <= 1'b0;
    end else if (bus.start) begin
      bus.err <= 1'b0;
    end else if (accept && is_min) begin
      bus.err <= 1'b1;
    end
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule
